osw_lane_sequencer: RTL and testbench
=====================================

OSW_LANE_SEQUENCER -- requirements
Module: osw_lane_sequencer

Interface
REQ-001 SHALL have parameter C_GUARD_CYCLES, default 16: cycles traffic stays gated before the switch drive changes (range 1..65535).
REQ-002 SHALL have parameter C_TIMEOUT_CYCLES, default 1000: maximum cycles to wait for switch status to match drive (range 1..65535).
REQ-003 SHALL have parameter C_RST_CYCLES, default 8: length of the common_rst pulse after a successful switch (range 1..65535).
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 switch_lane0_on / switch_lane1_on  in  1 each  requested drive level per lane.
REQ-007 osw_status0 / osw_status1  in  1 each  switch status feedback, asynchronous to aclk.
REQ-008 err_clr  in  1  single-cycle pulse clearing both error flags.
REQ-009 osw_drive0 / osw_drive1  out  1 each  switch driver outputs.
REQ-010 switch_lane0_done / switch_lane1_done  out  1 each  one-cycle pulse on successful switch completion.
REQ-011 common_gate  out  1  traffic enable; 1 = traffic allowed.
REQ-012 common_rst  out  1  traffic-generator reset pulse.
REQ-013 err_lane0 / err_lane1  out  1 each  sticky timeout flags.
REQ-014 busy  out  1  high in every state other than IDLE.

Function
REQ-015 Each status input SHALL pass through a 2-flop synchronizer before use; status_sync denotes the second-stage output.
REQ-016 Lane i SHALL be pending when switch_laneI_on != osw_driveI and err_laneI == 0.
REQ-017 FSM states: IDLE, GATE, DRIVE, RSTP, RESUME; all outputs registered.
REQ-018 IDLE: if any lane is pending, select one lane, latch its target level, and enter GATE on the next cycle; otherwise remain in IDLE.
REQ-019 Arbitration SHALL be round-robin: when both lanes are pending, select the lane not served last; the last-served pointer updates on entry to GATE.
REQ-020 GATE: common_gate = 0 for exactly C_GUARD_CYCLES cycles, then enter DRIVE.
REQ-021 DRIVE: osw_driveI takes the latched target on the first DRIVE cycle; the cycle counter restarts at 0.
REQ-022 DRIVE: if status_sync of the selected lane equals the target, enter RSTP on the next cycle.
REQ-023 DRIVE timeout: if the counter reaches C_TIMEOUT_CYCLES without a match, set err_laneI, keep the drive at the target, skip RSTP, and enter RESUME.
REQ-024 RSTP: common_rst = 1 for exactly C_RST_CYCLES cycles, common_gate = 0; then enter RESUME.
REQ-025 RESUME: lasts 1 cycle; common_gate returns to 1; switch_laneI_done pulses only on the success path; then enter IDLE.
REQ-026 common_gate SHALL be 0 in GATE, DRIVE and RSTP, and 1 in IDLE and RESUME.
REQ-027 Request changes while busy SHALL be ignored; they are re-evaluated in IDLE against the current drive.
REQ-028 A lane whose error flag is set SHALL NOT be selected; err_clr in IDLE clears both flags, and err_clr while busy is ignored.
REQ-029 Counters SHALL be 16-bit and saturate; no wrap-around.
REQ-030 Exactly one lane SHALL be switched per sequence; the unselected lane's drive SHALL NOT change.

Reset
REQ-031 While rst = 1, on each clock edge: state = IDLE, osw_drive0/1 = 0, common_gate = 1, common_rst = 0, done = 0, err = 0, busy = 0, synchronizers = 0, last-served = lane1 (lane0 first priority).
REQ-032 rst asserted mid-sequence SHALL abort the sequence and apply REQ-031 on the next edge; no done pulse is issued.

Verification (bench: status = drive delayed 4 cycles; GUARD=4, TIMEOUT=20, RST=3)
REQ-033 lane0_on 0->1 -> gate low 4 cycles, drive0 = 1, match seen 6 cycles later, common_rst high 3 cycles, gate high, done0 pulses once; drive1 stays 0.
REQ-034 lane0_on and lane1_on rise on the same cycle -> lane0 completes first, then lane1, giving 2 complete sequences and 2 done pulses in order 0 then 1.
REQ-035 status1 forced 0 and lane1_on = 1 -> after 20 DRIVE cycles err_lane1 = 1, no common_rst, no done1, gate restored; lane1 not retried until err_clr.
REQ-036 lane0_on toggles 1->0 during RSTP -> the current sequence finishes with done0; a second sequence then returns drive0 to 0.
REQ-037 rst pulsed during DRIVE -> next cycle all outputs at reset values, busy = 0, gate = 1.

Source files
------------

// File: rtl/osw_lane_sequencer_if.sv
// Signal bundle between a lane-switch requester and osw_lane_sequencer.
//   switch_lane0_on/1_on  : requested switch drive level per lane
//   osw_status0/1         : raw switch status feedback (asynchronous)
//   err_clr               : pulse clearing both sticky error flags
//   osw_drive0/1          : switch driver outputs
//   switch_lane0/1_done   : one-cycle pulse on successful switch
//   common_gate           : traffic enable (1 = traffic allowed)
//   common_rst            : traffic-generator reset pulse
//   err_lane0/1           : sticky timeout flags
//   busy                  : sequencer not idle
interface osw_lane_sequencer_if;
  logic switch_lane0_on;
  logic switch_lane1_on;
  logic osw_status0;
  logic osw_status1;
  logic err_clr;
  logic osw_drive0;
  logic osw_drive1;
  logic switch_lane0_done;
  logic switch_lane1_done;
  logic common_gate;
  logic common_rst;
  logic err_lane0;
  logic err_lane1;
  logic busy;

  modport master (
    output switch_lane0_on, switch_lane1_on, osw_status0, osw_status1, err_clr,
    input  osw_drive0, osw_drive1, switch_lane0_done, switch_lane1_done,
           common_gate, common_rst, err_lane0, err_lane1, busy
  );

  modport slave (
    input  switch_lane0_on, switch_lane1_on, osw_status0, osw_status1, err_clr,
    output osw_drive0, osw_drive1, switch_lane0_done, switch_lane1_done,
           common_gate, common_rst, err_lane0, err_lane1, busy
  );
endinterface

// File: rtl/osw_lane_sequencer.sv
// Optical-switch lane sequencer. Serialises lane switch requests: gates
// traffic for a guard interval, changes one lane's switch drive, waits for
// the synchronised status to follow, pulses the traffic-generator reset and
// re-enables traffic. A lane whose status never follows gets a sticky error
// and is skipped until err_clr arrives while idle.
// Ports:
//   aclk : clock, all logic on rising edge
//   rst  : synchronous active-high reset
//   osw  : osw_lane_sequencer_if.slave (requests/status in, drive/flags out)
module osw_lane_sequencer #(
  parameter int unsigned C_GUARD_CYCLES   = 16,
  parameter int unsigned C_TIMEOUT_CYCLES = 1000,
  parameter int unsigned C_RST_CYCLES     = 8
) (
  input  logic                  aclk,
  input  logic                  rst,
  osw_lane_sequencer_if.slave   osw
);

  typedef enum logic [2:0] {S_IDLE, S_GATE, S_DRIVE, S_RSTP, S_RESUME} state_t;

  // Terminal counts: each state lasts N cycles, counter runs 0..N-1.
  localparam logic [15:0] GUARD_LAST = 16'(C_GUARD_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(C_TIMEOUT_CYCLES - 1);
  localparam logic [15:0] RST_LAST   = 16'(C_RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        sel_q, sel_d;
  logic        tgt_q, tgt_d;
  logic        last_q, last_d;
  logic [1:0]  drive_q, drive_d;
  logic [1:0]  err_q, err_d;
  logic [1:0]  done_q, done_d;
  logic        gate_q, gate_d;
  logic        crst_q, crst_d;
  logic        busy_q, busy_d;
  logic [1:0]  sync_p0, sync_p1;
  logic [1:0]  req;
  logic [1:0]  pending;
  logic        pick;

  assign req     = {osw.switch_lane1_on, osw.switch_lane0_on};
  assign pending = (req ^ drive_q) & ~err_q;
  // Round-robin: on contention serve the lane not served last.
  assign pick    = (pending == 2'b11) ? ~last_q : pending[1];
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    last_d  = last_q;
    drive_d = drive_q;
    err_d   = err_q;
    done_d  = 2'b00;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (osw.err_clr) err_d = 2'b00;
        if (|pending) begin
          sel_d   = pick;
          tgt_d   = req[pick];
          last_d  = pick;
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (cnt_q >= GUARD_LAST) begin
          cnt_d          = 16'd0;
          drive_d[sel_q] = tgt_q;
          state_d        = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (sync_p1[sel_q] == tgt_q) begin
          cnt_d   = 16'd0;
          state_d = S_RSTP;
        end else if (cnt_q >= TO_LAST) begin
          // Drive stays at target; only the flag records the failure.
          cnt_d        = 16'd0;
          err_d[sel_q] = 1'b1;
          state_d      = S_RESUME;
        end
      end
      S_RSTP: begin
        if (cnt_q >= RST_LAST) begin
          cnt_d         = 16'd0;
          done_d[sel_q] = 1'b1;
          state_d       = S_RESUME;
        end
      end
      S_RESUME: begin
        cnt_d   = 16'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = S_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    gate_d = (state_d == S_IDLE) || (state_d == S_RESUME);
    crst_d = (state_d == S_RSTP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      last_q  <= 1'b1;
      drive_q <= 2'b00;
      err_q   <= 2'b00;
      done_q  <= 2'b00;
      gate_q  <= 1'b1;
      crst_q  <= 1'b0;
      busy_q  <= 1'b0;
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      drive_q <= drive_d;
      err_q   <= err_d;
      done_q  <= done_d;
      gate_q  <= gate_d;
      crst_q  <= crst_d;
      busy_q  <= busy_d;
      // Status synchroniser, stage 0 -> stage 1
      sync_p0 <= {osw.osw_status1, osw.osw_status0};
      sync_p1 <= sync_p0;
    end
  end

  // Lane select and target are only meaningful while busy; no reset needed.
  always_ff @(posedge aclk) begin
    sel_q <= sel_d;
    tgt_q <= tgt_d;
  end

  assign osw.osw_drive0        = drive_q[0];
  assign osw.osw_drive1        = drive_q[1];
  assign osw.switch_lane0_done = done_q[0];
  assign osw.switch_lane1_done = done_q[1];
  assign osw.common_gate       = gate_q;
  assign osw.common_rst        = crst_q;
  assign osw.err_lane0         = err_q[0];
  assign osw.err_lane1         = err_q[1];
  assign osw.busy              = busy_q;

endmodule

// File: tb/tb_osw_lane_sequencer.sv
// Directed bench for osw_lane_sequencer with GUARD=4, TIMEOUT=20, RST=3.
// Switch status is modelled as the drive delayed by 4 clocks; lane1 status
// can be forced low. Sample index k counts negedges after the request edge.
// Nominal switch timeline (k): gate low 1..14, drive at 5, common_rst 12..14,
// done at 15, idle again at 16.
module tb_osw_lane_sequencer;
  logic aclk = 1'b0;
  logic rst  = 1'b1;
  always #5 aclk = ~aclk;

  osw_lane_sequencer_if ifc ();

  osw_lane_sequencer #(
    .C_GUARD_CYCLES   (4),
    .C_TIMEOUT_CYCLES (20),
    .C_RST_CYCLES     (3)
  ) dut (
    .aclk (aclk),
    .rst  (rst),
    .osw  (ifc)
  );

  logic [3:0] dly0 = '0;
  logic [3:0] dly1 = '0;
  logic       force1 = 1'b0;
  always @(posedge aclk) begin
    dly0 <= {dly0[2:0], ifc.osw_drive0};
    dly1 <= {dly1[2:0], ifc.osw_drive1};
  end
  assign ifc.osw_status0 = dly0[3];
  assign ifc.osw_status1 = force1 ? 1'b0 : dly1[3];

  int n_checks = 0;
  int n_errors = 0;

  int obs_gate_lo, obs_rst_hi, obs_rst_first, obs_busy_hi;
  int obs_done0, obs_done1, obs_done0_at, obs_done1_at;
  int obs_drv0_chg, obs_drv1_chg, obs_drv0_at, obs_drv1_at, obs_err1_at;

  task automatic observe(input int n);
    logic p0, p1;
    obs_gate_lo = 0; obs_rst_hi = 0; obs_rst_first = 0; obs_busy_hi = 0;
    obs_done0 = 0; obs_done1 = 0; obs_done0_at = 0; obs_done1_at = 0;
    obs_drv0_chg = 0; obs_drv1_chg = 0; obs_drv0_at = 0; obs_drv1_at = 0;
    obs_err1_at = 0;
    p0 = ifc.osw_drive0;
    p1 = ifc.osw_drive1;
    for (int k = 1; k <= n; k++) begin
      @(negedge aclk);
      if (!ifc.common_gate) obs_gate_lo++;
      if (ifc.busy) obs_busy_hi++;
      if (ifc.common_rst) begin
        obs_rst_hi++;
        if (obs_rst_first == 0) obs_rst_first = k;
      end
      if (ifc.switch_lane0_done) begin
        obs_done0++;
        if (obs_done0_at == 0) obs_done0_at = k;
      end
      if (ifc.switch_lane1_done) begin
        obs_done1++;
        if (obs_done1_at == 0) obs_done1_at = k;
      end
      if (ifc.osw_drive0 !== p0) begin
        obs_drv0_chg++;
        if (obs_drv0_at == 0) obs_drv0_at = k;
      end
      if (ifc.osw_drive1 !== p1) begin
        obs_drv1_chg++;
        if (obs_drv1_at == 0) obs_drv1_at = k;
      end
      if (ifc.err_lane1 && obs_err1_at == 0) obs_err1_at = k;
      p0 = ifc.osw_drive0;
      p1 = ifc.osw_drive1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.switch_lane0_on = 1'b0;
    ifc.switch_lane1_on = 1'b0;
    ifc.err_clr = 1'b0;
    force1 = 1'b0;
    repeat (6) @(negedge aclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    ifc.switch_lane0_on = 1'b1;
    @(negedge aclk);
    n_checks++; if (ifc.osw_drive0 !== 1'b0) begin n_errors++; $display("FAIL reset drive0: got %b want 0", ifc.osw_drive0); end
    n_checks++; if (ifc.osw_drive1 !== 1'b0) begin n_errors++; $display("FAIL reset drive1: got %b want 0", ifc.osw_drive1); end
    n_checks++; if (ifc.common_gate !== 1'b1) begin n_errors++; $display("FAIL reset gate: got %b want 1", ifc.common_gate); end
    n_checks++; if (ifc.common_rst !== 1'b0) begin n_errors++; $display("FAIL reset common_rst: got %b want 0", ifc.common_rst); end
    n_checks++; if (ifc.busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b want 0", ifc.busy); end
    n_checks++; if ({ifc.err_lane1, ifc.err_lane0} !== 2'b00) begin n_errors++; $display("FAIL reset err: got %b%b want 00", ifc.err_lane1, ifc.err_lane0); end
    n_checks++; if ({ifc.switch_lane1_done, ifc.switch_lane0_done} !== 2'b00) begin n_errors++; $display("FAIL reset done: got %b%b want 00", ifc.switch_lane1_done, ifc.switch_lane0_done); end
    ifc.switch_lane0_on = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_single_switch();
    ifc.switch_lane0_on = 1'b1;
    observe(20);
    n_checks++; if (obs_gate_lo !== 14) begin n_errors++; $display("FAIL single gate_low: got %0d want 14", obs_gate_lo); end
    n_checks++; if (obs_drv0_at !== 5) begin n_errors++; $display("FAIL single drive0_at: got %0d want 5", obs_drv0_at); end
    n_checks++; if (obs_rst_first !== 12) begin n_errors++; $display("FAIL single rst_first: got %0d want 12", obs_rst_first); end
    n_checks++; if (obs_rst_hi !== 3) begin n_errors++; $display("FAIL single rst_cycles: got %0d want 3", obs_rst_hi); end
    n_checks++; if (obs_done0 !== 1 || obs_done0_at !== 15) begin n_errors++; $display("FAIL single done0: got %0d@%0d want 1@15", obs_done0, obs_done0_at); end
    n_checks++; if (obs_done1 !== 0 || obs_drv1_chg !== 0) begin n_errors++; $display("FAIL single lane1: got done %0d chg %0d want 0 0", obs_done1, obs_drv1_chg); end
    n_checks++; if (obs_busy_hi !== 15) begin n_errors++; $display("FAIL single busy_cycles: got %0d want 15", obs_busy_hi); end
    n_checks++; if (ifc.osw_drive0 !== 1'b1 || ifc.common_gate !== 1'b1) begin n_errors++; $display("FAIL single end: got drive0 %b gate %b want 1 1", ifc.osw_drive0, ifc.common_gate); end
  endtask

  // Lane0 was served last, so with both pending lane1 must go first.
  task automatic test_round_robin();
    ifc.switch_lane0_on = 1'b0;
    ifc.switch_lane1_on = 1'b1;
    observe(40);
    n_checks++; if (obs_done1_at !== 15) begin n_errors++; $display("FAIL rr done1_at: got %0d want 15", obs_done1_at); end
    n_checks++; if (obs_done0_at !== 31) begin n_errors++; $display("FAIL rr done0_at: got %0d want 31", obs_done0_at); end
    n_checks++; if (obs_drv1_at !== 5 || obs_drv0_at !== 21) begin n_errors++; $display("FAIL rr drive_at: got %0d/%0d want 5/21", obs_drv1_at, obs_drv0_at); end
    n_checks++; if (obs_gate_lo !== 28 || obs_rst_hi !== 6) begin n_errors++; $display("FAIL rr gate/rst: got %0d/%0d want 28/6", obs_gate_lo, obs_rst_hi); end
    n_checks++; if ({ifc.osw_drive1, ifc.osw_drive0} !== 2'b10) begin n_errors++; $display("FAIL rr drives: got %b%b want 10", ifc.osw_drive1, ifc.osw_drive0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ifc.switch_lane0_on = 1'b1;
    ifc.switch_lane1_on = 1'b1;
    observe(40);
    n_checks++; if (obs_done0 !== 1 || obs_done0_at !== 15) begin n_errors++; $display("FAIL b2b done0: got %0d@%0d want 1@15", obs_done0, obs_done0_at); end
    n_checks++; if (obs_done1 !== 1 || obs_done1_at !== 31) begin n_errors++; $display("FAIL b2b done1: got %0d@%0d want 1@31", obs_done1, obs_done1_at); end
    n_checks++; if (obs_rst_hi !== 6 || obs_gate_lo !== 28) begin n_errors++; $display("FAIL b2b rst/gate: got %0d/%0d want 6/28", obs_rst_hi, obs_gate_lo); end
    n_checks++; if ({ifc.osw_drive1, ifc.osw_drive0} !== 2'b11 || ifc.busy !== 1'b0) begin n_errors++; $display("FAIL b2b end: got drives %b%b busy %b want 11 0", ifc.osw_drive1, ifc.osw_drive0, ifc.busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    force1 = 1'b1;
    ifc.switch_lane1_on = 1'b1;
    observe(30);
    n_checks++; if (obs_err1_at !== 25) begin n_errors++; $display("FAIL timeout err1_at: got %0d want 25", obs_err1_at); end
    n_checks++; if (obs_gate_lo !== 24 || obs_busy_hi !== 25) begin n_errors++; $display("FAIL timeout gate/busy: got %0d/%0d want 24/25", obs_gate_lo, obs_busy_hi); end
    n_checks++; if (obs_rst_hi !== 0 || obs_done1 !== 0) begin n_errors++; $display("FAIL timeout rst/done1: got %0d/%0d want 0/0", obs_rst_hi, obs_done1); end
    n_checks++; if (ifc.osw_drive1 !== 1'b1 || ifc.common_gate !== 1'b1) begin n_errors++; $display("FAIL timeout end: got drive1 %b gate %b want 1 1", ifc.osw_drive1, ifc.common_gate); end
    // Lane0 sequence with err_clr pulsed while busy: flag must survive.
    ifc.switch_lane0_on = 1'b1;
    repeat (2) @(negedge aclk);
    ifc.err_clr = 1'b1;
    @(negedge aclk);
    ifc.err_clr = 1'b0;
    observe(20);
    n_checks++; if (obs_done0 !== 1 || obs_done0_at !== 12) begin n_errors++; $display("FAIL busyclr done0: got %0d@%0d want 1@12", obs_done0, obs_done0_at); end
    n_checks++; if (ifc.err_lane1 !== 1'b1) begin n_errors++; $display("FAIL busyclr err1: got %b want 1", ifc.err_lane1); end
    n_checks++; if (obs_busy_hi !== 12 || obs_done1 !== 0) begin n_errors++; $display("FAIL no_retry busy/done1: got %0d/%0d want 12/0", obs_busy_hi, obs_done1); end
    ifc.err_clr = 1'b1;
    @(negedge aclk);
    ifc.err_clr = 1'b0;
    n_checks++; if (ifc.err_lane1 !== 1'b0) begin n_errors++; $display("FAIL idleclr err1: got %b want 0", ifc.err_lane1); end
    force1 = 1'b0;
  endtask

  task automatic test_toggle_in_rstp();
    int k;
    do_reset();
    ifc.switch_lane0_on = 1'b1;
    k = 0;
    while (k < 30 && ifc.common_rst !== 1'b1) begin
      @(negedge aclk);
      k++;
    end
    n_checks++; if (k !== 12) begin n_errors++; $display("FAIL toggle rst_reach: got %0d want 12", k); end
    ifc.switch_lane0_on = 1'b0;
    observe(30);
    n_checks++; if (obs_done0 !== 2 || obs_done0_at !== 3) begin n_errors++; $display("FAIL toggle done0: got %0d@%0d want 2@3", obs_done0, obs_done0_at); end
    n_checks++; if (obs_rst_hi !== 5 || obs_drv0_at !== 9) begin n_errors++; $display("FAIL toggle rst/drv_at: got %0d/%0d want 5/9", obs_rst_hi, obs_drv0_at); end
    n_checks++; if (ifc.osw_drive0 !== 1'b0 || ifc.err_lane0 !== 1'b0) begin n_errors++; $display("FAIL toggle end: got drive0 %b err0 %b want 0 0", ifc.osw_drive0, ifc.err_lane0); end
  endtask

  task automatic test_reset_in_drive();
    int k;
    do_reset();
    ifc.switch_lane1_on = 1'b1;
    k = 0;
    while (k < 20 && ifc.osw_drive1 !== 1'b1) begin
      @(negedge aclk);
      k++;
    end
    n_checks++; if (k !== 5) begin n_errors++; $display("FAIL abort drive_reach: got %0d want 5", k); end
    @(negedge aclk);
    rst = 1'b1;
    ifc.switch_lane1_on = 1'b0;
    @(negedge aclk);
    n_checks++; if ({ifc.osw_drive1, ifc.osw_drive0} !== 2'b00) begin n_errors++; $display("FAIL abort drives: got %b%b want 00", ifc.osw_drive1, ifc.osw_drive0); end
    n_checks++; if (ifc.busy !== 1'b0 || ifc.common_gate !== 1'b1 || ifc.common_rst !== 1'b0) begin n_errors++; $display("FAIL abort ctl: got busy %b gate %b rst %b want 0 1 0", ifc.busy, ifc.common_gate, ifc.common_rst); end
    n_checks++; if ({ifc.switch_lane1_done, ifc.switch_lane0_done, ifc.err_lane1, ifc.err_lane0} !== 4'b0000) begin n_errors++; $display("FAIL abort flags: got %b%b%b%b want 0000", ifc.switch_lane1_done, ifc.switch_lane0_done, ifc.err_lane1, ifc.err_lane0); end
    rst = 1'b0;
    observe(10);
    n_checks++; if (obs_busy_hi !== 0 || obs_done1 !== 0) begin n_errors++; $display("FAIL abort after: got busy %0d done1 %0d want 0 0", obs_busy_hi, obs_done1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.switch_lane0_on = 1'b0;
    ifc.switch_lane1_on = 1'b0;
    ifc.err_clr = 1'b0;
    test_reset();
    test_single_switch();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_toggle_in_rstp();
    test_reset_in_drive();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
